regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port (dest_en/dest_addr/dest_data) between NUM_REQ writeback sources, such as the ALU, load unit and CSR unit. Arbitration is round-robin with a valid/ready handshake per requester. The winning write is driven into the regfile through one registered output stage. The block also keeps a pending-write scoreboard that issue logic uses to detect RAW hazards; it sits between the execute/writeback units and regfile.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_wb_arbiter_if.sv | 26 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback path, the regfile and their benches.
package regfile_pkg;

   localparam int unsigned WIDTH      = 32;
   localparam int unsigned ADDR_WIDTH = 5;
   localparam int unsigned REG_COUNT  = 1 << ADDR_WIDTH;

   typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [WIDTH-1:0]      reg_data_t;

   typedef struct packed {
      reg_addr_t addr;
      reg_data_t data;
   } wb_req_t;

   // Round-robin successor of idx among n slots; valid for any n, not just powers of two.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: NUM_REQ valid/ready channels with packed address and data slices.
interface regfile_wb_arbiter_if #(
   parameter int unsigned NUM_REQ = 3
);
   import regfile_pkg::*;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*WIDTH-1:0]      req_data;

   modport master (
      output req_valid,
      output req_addr,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int unsigned PtrW = $clog2(N);

   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         int unsigned idx;
         idx = (32'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PtrW'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter with registered regfile write port and pending-write scoreboard.
// Optional macro REGFILE_WB_BYPASS_EN enables the rs1/rs2 forwarding check from the output stage.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_wb_arbiter_if.slave   bus,
   input  logic                  set_en,
   input  reg_addr_t             set_addr,
   output logic [REG_COUNT-1:0]  pending,
   output logic                  dest_en,
   output reg_addr_t             dest_addr,
   output reg_data_t             dest_data,
   input  reg_addr_t             rs1_addr,
   input  reg_addr_t             rs2_addr,
   output logic                  rs1_fwd_hit,
   output logic                  rs2_fwd_hit,
   output reg_data_t             rs1_fwd_data,
   output reg_data_t             rs2_fwd_data
);

   localparam int unsigned PtrW = $clog2(NUM_REQ);

   logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]   req_masked;
   logic [NUM_REQ-1:0]   grant;
   logic [PtrW-1:0]      grant_idx;
   logic                 grant_any;
   wb_req_t              req [NUM_REQ];
   wb_req_t              win;
   logic                 win_write;
   logic [REG_COUNT-1:0] pending_q, pending_d;

   // Requests are masked during reset so no handshake can complete on a reset edge.
   assign req_masked = bus.req_valid & {NUM_REQ{rst_n}};

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr_arbiter (
      .req       (req_masked),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign bus.req_ready = grant;
   assign grant_any     = |grant;

   always_comb begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         req[i].addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         req[i].data = bus.req_data[i*WIDTH +: WIDTH];
      end
   end

   assign win       = req[grant_idx];
   assign win_write = grant_any && (win.addr != '0);

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         rr_ptr_d = PtrW'(rr_next(32'(grant_idx), NUM_REQ));
      end
   end

   // Clear before set so a same-cycle set on the retiring register wins.
   always_comb begin
      pending_d = pending_q;
      if (grant_any) begin
         pending_d[win.addr] = 1'b0;
      end
      if (set_en && (set_addr != '0)) begin
         pending_d[set_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q  <= '0;
         pending_q <= '0;
         dest_en   <= 1'b0;
         dest_addr <= '0;
         dest_data <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         pending_q <= pending_d;
         dest_en   <= win_write;
         if (win_write) begin
            dest_addr <= win.addr;
            dest_data <= win.data;
         end
      end
   end

   assign pending = pending_q;

`ifdef REGFILE_WB_BYPASS_EN
   assign rs1_fwd_hit  = dest_en && (dest_addr == rs1_addr) && (rs1_addr != '0);
   assign rs2_fwd_hit  = dest_en && (dest_addr == rs2_addr) && (rs2_addr != '0);
   assign rs1_fwd_data = dest_data;
   assign rs2_fwd_data = dest_data;
`else
   logic unused_rs;
   assign unused_rs    = ^{rs1_addr, rs2_addr};
   assign rs1_fwd_hit  = 1'b0;
   assign rs2_fwd_hit  = 1'b0;
   assign rs1_fwd_data = '0;
   assign rs2_fwd_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic against a behavioural model.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   localparam int NR = 3;

   logic      clk;
   logic      rst_n;
   logic      set_en;
   reg_addr_t set_addr;
   reg_addr_t rs1_addr, rs2_addr;
   logic [REG_COUNT-1:0] pending;
   logic      dest_en;
   reg_addr_t dest_addr;
   reg_data_t dest_data;
   logic      rs1_fwd_hit, rs2_fwd_hit;
   reg_data_t rs1_fwd_data, rs2_fwd_data;

   logic [NR-1:0] valid;
   reg_addr_t     a [NR];
   reg_data_t     d [NR];

   regfile_wb_arbiter_if #(.NUM_REQ(NR)) bus ();

   assign bus.req_valid = valid;
   assign bus.req_addr  = {a[2], a[1], a[0]};
   assign bus.req_data  = {d[2], d[1], d[0]};

   regfile_wb_arbiter #(.NUM_REQ(NR)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .set_en       (set_en),
      .set_addr     (set_addr),
      .pending      (pending),
      .dest_en      (dest_en),
      .dest_addr    (dest_addr),
      .dest_data    (dest_data),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_fwd_hit  (rs1_fwd_hit),
      .rs2_fwd_hit  (rs2_fwd_hit),
      .rs1_fwd_data (rs1_fwd_data),
      .rs2_fwd_data (rs2_fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference state, derived from the rules: priority pointer, pending set, last regfile write.
   int            m_ptr;
   logic [31:0]   m_pend;
   logic          m_en;
   logic [4:0]    m_addr;
   logic [31:0]   m_data;
   logic [NR-1:0] last_grant;
   logic [NR-1:0] gq [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic h1, h2;
      chk("dest_en", 64'(dest_en), 64'(m_en));
      chk("pending", 64'(pending), 64'(m_pend));
      if (m_en) begin
         chk("dest_addr", 64'(dest_addr), 64'(m_addr));
         chk("dest_data", 64'(dest_data), 64'(m_data));
      end
`ifdef REGFILE_WB_BYPASS_EN
      h1 = m_en && (m_addr == rs1_addr) && (rs1_addr != 0);
      h2 = m_en && (m_addr == rs2_addr) && (rs2_addr != 0);
      if (h1) chk("rs1_fwd_data", 64'(rs1_fwd_data), 64'(m_data));
      if (h2) chk("rs2_fwd_data", 64'(rs2_fwd_data), 64'(m_data));
`else
      h1 = 1'b0;
      h2 = 1'b0;
      chk("rs1_fwd_data", 64'(rs1_fwd_data), 64'd0);
      chk("rs2_fwd_data", 64'(rs2_fwd_data), 64'd0);
`endif
      chk("rs1_fwd_hit", 64'(rs1_fwd_hit), 64'(h1));
      chk("rs2_fwd_hit", 64'(rs2_fwd_hit), 64'(h2));
   endtask

   // Inputs are already driven; check ready, clock once, advance the model, check outputs.
   task automatic cycle();
      logic [NR-1:0] exp_rdy;
      int g;
      #1;
      g = -1;
      exp_rdy = '0;
      if (rst_n) begin
         for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (g < 0 && valid[idx]) g = idx;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      last_grant = exp_rdy;
      gq.push_back(exp_rdy);
      @(posedge clk);
      if (!rst_n) begin
         m_ptr = 0; m_pend = '0; m_en = 1'b0; m_addr = '0; m_data = '0;
      end else begin
         m_en = 1'b0;
         if (g >= 0) begin
            m_ptr = (g + 1) % NR;
            m_pend[a[g]] = 1'b0;
            if (a[g] != 0) begin
               m_en = 1'b1; m_addr = a[g]; m_data = d[g];
            end
         end
         if (set_en && set_addr != 0) m_pend[set_addr] = 1'b1;
      end
      #1;
      check_outputs();
   endtask

   initial begin
      logic [NR-1:0] exp_seq [4];
      m_ptr = 0; m_pend = '0; m_en = 1'b0; m_addr = '0; m_data = '0;
      rst_n = 1'b0; valid = '0; set_en = 1'b0; set_addr = '0;
      rs1_addr = '0; rs2_addr = '0;
      for (int i = 0; i < NR; i++) begin a[i] = '0; d[i] = '0; end

      cycle();
      cycle();
      chk("reset_dest_addr", 64'(dest_addr), 64'd0);
      chk("reset_dest_data", 64'(dest_data), 64'd0);
      rst_n = 1'b1;

      // All three valid from pointer 0: grants rotate 0,1,2,0.
      valid = 3'b111;
      a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
      d[0] = 32'hA1; d[1] = 32'hB2; d[2] = 32'hC3;
      gq.delete();
      repeat (4) cycle();
      exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
      for (int i = 0; i < 4; i++) chk("rr_order", 64'(gq[i]), 64'(exp_seq[i]));
      chk("rr_last_addr", 64'(dest_addr), 64'd1);
      chk("rr_last_data", 64'(dest_data), 64'hA1);

      // Lone requester 2 streams x7 back to back.
      valid = 3'b100; a[2] = 5'd7;
      for (int j = 0; j < 4; j++) begin
         d[2] = 32'h100 + 32'(j);
         cycle();
         chk("lone_ready", 64'(last_grant), 64'(3'b100));
         chk("lone_data", 64'(dest_data), 64'(32'h100 + 32'(j)));
      end

      // Write to x0 completes the handshake but never reaches the regfile.
      valid = 3'b010; a[1] = 5'd0; d[1] = 32'hDEADBEEF;
      cycle();
      chk("x0_ready", 64'(last_grant), 64'(3'b010));
      chk("x0_dest_en", 64'(dest_en), 64'd0);

      // Same-cycle set and retire of x5: set wins; a later plain retire clears it.
      valid = '0; set_en = 1'b1; set_addr = 5'd5;
      cycle();
      valid = 3'b001; a[0] = 5'd5; d[0] = 32'h55;
      cycle();
      chk("set_wins", 64'(pending[5]), 64'd1);
      set_en = 1'b0;
      cycle();
      chk("retire_x5", 64'(pending[5]), 64'd0);

      // Reset lands on a cycle where x9 is requested: x9 must never be written.
      valid = '0; set_en = 1'b1; set_addr = 5'd9;
      cycle();
      set_en = 1'b0; valid = 3'b001; a[0] = 5'd9; d[0] = 32'h99;
      rst_n = 1'b0;
      cycle();
      chk("rst_pending", 64'(pending), 64'd0);
      rst_n = 1'b1; valid = '0;
      cycle();
      chk("rst_no_x9", 64'(dest_en), 64'd0);
      valid = 3'b111; a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
      cycle();
      chk("rst_ptr", 64'(last_grant), 64'(3'b001));

      // Bypass: grant x4 then look it up on rs1 while rs2 points at x0.
      valid = 3'b001; a[0] = 5'd4; d[0] = 32'h12345678;
      rs1_addr = 5'd4; rs2_addr = 5'd0;
      cycle();
`ifdef REGFILE_WB_BYPASS_EN
      chk("byp_rs1_hit", 64'(rs1_fwd_hit), 64'd1);
      chk("byp_rs1_data", 64'(rs1_fwd_data), 64'h12345678);
`else
      chk("byp_rs1_hit", 64'(rs1_fwd_hit), 64'd0);
`endif
      chk("byp_rs2_hit", 64'(rs2_fwd_hit), 64'd0);

      // Random traffic: each requester holds its write until granted.
      valid = '0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!valid[i] || last_grant[i]) begin
               valid[i] = ($urandom_range(0, 9) < 6);
               a[i] = 5'($urandom);
               d[i] = $urandom;
            end
         end
         set_en   = $urandom_range(0, 1) == 1;
         set_addr = 5'($urandom);
         rs1_addr = ($urandom_range(0, 1) == 1) ? a[$urandom_range(0, NR-1)] : 5'($urandom);
         rs2_addr = ($urandom_range(0, 1) == 1) ? m_addr : 5'($urandom);
         rst_n    = ($urandom_range(0, 59) != 0);
         if (!rst_n) valid = '0;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
